wbu_csr_writer: RTL and testbench
=================================

Name: wbu_csr_writer

Overview:
- Write-back-stage CSR write sequencer. It is the writer for the single-write-port CSR file that IDU reads.
- Accepts one retiring CSR-class instruction at a time: CSRRW, CSRRS, CSRRC, ECALL or MRET.
- Computes the new CSR values and drives CSRWr / WBU_csr_rd / csr_busW, one write per cycle.
- Multi-write trap sequences are serialised through that one port; upstream is stalled while they run.

Parameters:
ECALL_CAUSE, 32'h0000000B, value written to mcause on ECALL
MPP_M, 2'b11, privilege encoding forced into mstatus.MPP

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  instruction accepted when in_valid&in_ready
in_op  in  3  0 NONE, 1 CSRRW, 2 CSRRS, 3 CSRRC, 4 ECALL, 5 MRET; 6-7 treated as NONE
in_csr_rd  in  3  target CSR index (CSR ops only)
in_csr_old  in  32  current value of target CSR, read in IDU
in_src  in  32  rs1 value or zero-extended zimm
in_pc  in  32  PC of the instruction
in_mstatus  in  32  current mstatus
in_mtvec  in  32  current mtvec
in_mepc  in  32  current mepc
CSRWr  out  1  CSR write enable
WBU_csr_rd  out  3  CSR write index
csr_busW  out  32  CSR write data
redirect_valid  out  1  one-cycle PC redirect pulse
redirect_pc  out  32  redirect target
ro_err  out  1  one-cycle pulse: write to read-only or unimplemented index suppressed

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- CSR indices: mstatus=0, mtvec=1, mepc=2, mcause=3, mvendorid=4, marchid=5.
  - 4 and 5 are read-only; 6 and 7 are unimplemented.
- All outputs are registered.
- On rst: state=IDLE; CSRWr=0, WBU_csr_rd=0, csr_busW=0, redirect_valid=0, redirect_pc=0, ro_err=0.
- rst mid-sequence aborts immediately; remaining writes are not issued.
- FSM states. Each state's name is what is on the write port that cycle:
  - IDLE: no write.
  - S_CSR: single CSR write.
  - S_MEPC, S_MCAUSE: first two ECALL writes.
  - S_MSTATUS: final write of ECALL or the only write of MRET.
- in_ready = state ∈ {IDLE, S_CSR, S_MSTATUS}. A new instruction is accepted in the last cycle of the previous one, so CSR ops sustain 1 per cycle.
- On accept, next state by op:
  - CSRRW/RS/RC → S_CSR.
  - ECALL → S_MEPC.
  - MRET → S_MSTATUS.
  - NONE → IDLE.
- On accept, in_pc, in_mstatus, in_mtvec and in_mepc are latched for the sequence.
- No accept from an accepting state → IDLE. S_MEPC → S_MCAUSE → S_MSTATUS unconditionally.
- CSR write value:
  - RW: in_src.
  - RS: in_csr_old | in_src.
  - RC: in_csr_old & ~in_src.
- RS/RC with in_src==0: CSRWr stays 0 (no write).
- Target index ≥4: CSRWr stays 0 and ro_err=1 in the S_CSR cycle.
  - Exception: RS/RC with in_src==0 raises no ro_err.
- ECALL writes, one per cycle:
  - S_MEPC: index 2 ← pc.
  - S_MCAUSE: index 3 ← ECALL_CAUSE.
  - S_MSTATUS: index 0 ← mstatus with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=MPP_M.
  - redirect_valid=1 with redirect_pc=latched mtvec in the S_MSTATUS cycle.
- MRET write, S_MSTATUS: index 0 ← mstatus with MIE=MPIE, MPIE=1, MPP=MPP_M.
  - redirect_valid=1 with redirect_pc=latched mepc in the same cycle.
- Latency: accept at edge N → write visible on port in cycle N+1.
  - ECALL occupies N+1..N+3; MRET occupies N+1.
- Read-after-write hazards from back-to-back ops (stale in_csr_old / in_mstatus) are resolved upstream by forwarding or stall. This block uses its inputs as given.
- Other bits of csr_busW pass through unchanged from the latched mstatus.

Decomposition:
- Shared package: CSR index constants, the csr_op_e enum, mstatus bit positions (MIE=3, MPIE=7, MPP=12:11) and the FSM state enum.
- One natural sub-module, csr_alu: a combinational RW/RS/RC value and write-suppress computation, reusable by forwarding logic.

Test Plan:
- Reset, then CSRRW rd=1 src=0x80000100 → next cycle CSRWr=1, WBU_csr_rd=1, csr_busW=0x80000100; in_ready stays 1.
- CSRRS rd=0 old=0x1800 src=0x8, then in the following cycle CSRRC rd=0 old=0x1808 src=0x1000:
  - cycle N+1: csr_busW=0x1808;
  - cycle N+2: csr_busW=0x0808;
  - in_ready high throughout.
- ECALL pc=0x80000040, mstatus=0x1808, mtvec=0x80000200:
  - three consecutive writes: (2, 0x80000040), (3, 0xB), (0, 0x1880);
  - redirect_valid with 0x80000200 in the third cycle;
  - in_ready=0 during the first two.
- MRET mstatus=0x1880, mepc=0x80000044 → single write (0, 0x1888); redirect_pc=0x80000044 in the same cycle.
- CSRRW rd=4 → CSRWr=0, ro_err=1 for one cycle. CSRRS rd=2 src=0 → no write, no ro_err.
- ECALL accepted, rst asserted during S_MCAUSE → next cycle all outputs 0, state IDLE, and no S_MSTATUS write ever appears.

Source files
------------

// File: rtl/wbu_csr_writer_pkg.sv
// Shared definitions for the write-back CSR writer: CSR indices, op and state
// encodings, mstatus field positions and the trap mstatus transforms.
package wbu_csr_writer_pkg;

    localparam logic [2:0] CSR_MSTATUS   = 3'd0;
    localparam logic [2:0] CSR_MTVEC     = 3'd1;
    localparam logic [2:0] CSR_MEPC      = 3'd2;
    localparam logic [2:0] CSR_MCAUSE    = 3'd3;
    localparam logic [2:0] CSR_MVENDORID = 3'd4;
    localparam logic [2:0] CSR_MARCHID   = 3'd5;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CSRRW = 3'd1,
        OP_CSRRS = 3'd2,
        OP_CSRRC = 3'd3,
        OP_ECALL = 3'd4,
        OP_MRET  = 3'd5
    } csr_op_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        S_CSR     = 3'd1,
        S_MEPC    = 3'd2,
        S_MCAUSE  = 3'd3,
        S_MSTATUS = 3'd4
    } state_e;

    function automatic logic [31:0] ecall_mstatus(input logic [31:0] ms, input logic [1:0] mpp);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms, input logic [1:0] mpp);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp;
        return r;
    endfunction

endpackage

// File: rtl/wbu_csr_writer_csr_alu.sv
// Combinational CSRRW/RS/RC new-value and write-suppress logic; usable by
// forwarding paths as well as the writer itself.
module csr_alu
    import wbu_csr_writer_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [2:0]  csr_rd,
    input  logic [31:0] csr_old,
    input  logic [31:0] src,
    output logic [31:0] wdata,
    output logic        wr_en,
    output logic        ro_err
);

    logic is_csr;
    logic no_write;
    logic read_only;

    always_comb begin
        is_csr   = 1'b0;
        no_write = 1'b0;
        wdata    = '0;
        case (op)
            OP_CSRRW: begin
                is_csr = 1'b1;
                wdata  = src;
            end
            OP_CSRRS: begin
                is_csr   = 1'b1;
                wdata    = csr_old | src;
                no_write = (src == '0);
            end
            OP_CSRRC: begin
                is_csr   = 1'b1;
                wdata    = csr_old & ~src;
                no_write = (src == '0);
            end
            default: ;
        endcase
    end

    // Indices 4..7 are read-only or unimplemented; a set/clear with zero
    // source never intends a write, so it raises no error either.
    assign read_only = (csr_rd >= CSR_MVENDORID);
    assign wr_en     = is_csr && !no_write && !read_only;
    assign ro_err    = is_csr && !no_write && read_only;

endmodule

// File: rtl/wbu_csr_writer.sv
// Write-back CSR write sequencer: one CSR write per cycle, serialising the
// ECALL/MRET trap updates through the single write port.
module wbu_csr_writer
    import wbu_csr_writer_pkg::*;
#(
    parameter logic [31:0] ECALL_CAUSE = 32'h0000_000B,
    parameter logic [1:0]  MPP_M       = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [2:0]  in_csr_rd,
    input  logic [31:0] in_csr_old,
    input  logic [31:0] in_src,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_mstatus,
    input  logic [31:0] in_mtvec,
    input  logic [31:0] in_mepc,
    output logic        CSRWr,
    output logic [2:0]  WBU_csr_rd,
    output logic [31:0] csr_busW,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        ro_err
);

    state_e      state, state_n;
    logic        accept;
    logic [31:0] mstatus_q;
    logic [31:0] mtvec_q;

    logic        wr_n;
    logic [2:0]  rd_n;
    logic [31:0] data_n;
    logic        redir_n;
    logic [31:0] rpc_n;
    logic        ro_n;

    logic [31:0] alu_wdata;
    logic        alu_wr;
    logic        alu_ro;

    csr_alu u_csr_alu (
        .op      (in_op),
        .csr_rd  (in_csr_rd),
        .csr_old (in_csr_old),
        .src     (in_src),
        .wdata   (alu_wdata),
        .wr_en   (alu_wr),
        .ro_err  (alu_ro)
    );

    assign in_ready = (state == IDLE) || (state == S_CSR) || (state == S_MSTATUS);
    assign accept   = in_valid && in_ready;

    // Outputs are computed one cycle ahead from the next state so every port
    // comes straight from a flop; pc and mepc are consumed on the accept
    // cycle itself and therefore need no holding register.
    always_comb begin
        state_n = state;
        wr_n    = 1'b0;
        rd_n    = '0;
        data_n  = '0;
        redir_n = 1'b0;
        rpc_n   = '0;
        ro_n    = 1'b0;
        case (state)
            IDLE, S_CSR, S_MSTATUS: begin
                state_n = IDLE;
                if (accept) begin
                    case (in_op)
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
                            state_n = S_CSR;
                            wr_n    = alu_wr;
                            rd_n    = alu_wr ? in_csr_rd : '0;
                            data_n  = alu_wr ? alu_wdata : '0;
                            ro_n    = alu_ro;
                        end
                        OP_ECALL: begin
                            state_n = S_MEPC;
                            wr_n    = 1'b1;
                            rd_n    = CSR_MEPC;
                            data_n  = in_pc;
                        end
                        OP_MRET: begin
                            state_n = S_MSTATUS;
                            wr_n    = 1'b1;
                            rd_n    = CSR_MSTATUS;
                            data_n  = mret_mstatus(in_mstatus, MPP_M);
                            redir_n = 1'b1;
                            rpc_n   = in_mepc;
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
            S_MEPC: begin
                state_n = S_MCAUSE;
                wr_n    = 1'b1;
                rd_n    = CSR_MCAUSE;
                data_n  = ECALL_CAUSE;
            end
            S_MCAUSE: begin
                state_n = S_MSTATUS;
                wr_n    = 1'b1;
                rd_n    = CSR_MSTATUS;
                data_n  = ecall_mstatus(mstatus_q, MPP_M);
                redir_n = 1'b1;
                rpc_n   = mtvec_q;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            CSRWr          <= 1'b0;
            WBU_csr_rd     <= '0;
            csr_busW       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            ro_err         <= 1'b0;
            mstatus_q      <= '0;
            mtvec_q        <= '0;
        end else begin
            state          <= state_n;
            CSRWr          <= wr_n;
            WBU_csr_rd     <= rd_n;
            csr_busW       <= data_n;
            redirect_valid <= redir_n;
            redirect_pc    <= rpc_n;
            ro_err         <= ro_n;
            if (accept) begin
                mstatus_q <= in_mstatus;
                mtvec_q   <= in_mtvec;
            end
        end
    end

endmodule

// File: tb/tb_wbu_csr_writer.sv
// Scoreboard bench for wbu_csr_writer: a per-instruction reference model
// queues expected port events, a negedge monitor matches them.
module tb_wbu_csr_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [2:0]  in_csr_rd = '0;
    logic [31:0] in_csr_old = '0;
    logic [31:0] in_src = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_mstatus = '0;
    logic [31:0] in_mtvec = '0;
    logic [31:0] in_mepc = '0;
    logic        CSRWr;
    logic [2:0]  WBU_csr_rd;
    logic [31:0] csr_busW;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ro_err;

    wbu_csr_writer #(.ECALL_CAUSE(32'h0000_000B), .MPP_M(2'b11)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_csr_rd(in_csr_rd), .in_csr_old(in_csr_old),
        .in_src(in_src), .in_pc(in_pc), .in_mstatus(in_mstatus),
        .in_mtvec(in_mtvec), .in_mepc(in_mepc), .CSRWr(CSRWr),
        .WBU_csr_rd(WBU_csr_rd), .csr_busW(csr_busW),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ro_err(ro_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        cyc;
        bit        wr;
        bit [2:0]  rd;
        bit [31:0] data;
        bit        ro;
        bit        redir;
        bit [31:0] rpc;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  next_ok = 0;
    bit  started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic ev_t mk(input int c, input bit wr, input bit [2:0] rd, input bit [31:0] d,
                               input bit ro, input bit redir, input bit [31:0] rpc);
        ev_t e;
        e.cyc = c; e.wr = wr; e.rd = rd; e.data = d; e.ro = ro; e.redir = redir; e.rpc = rpc;
        return e;
    endfunction

    // Trap mstatus rules expressed as bit arithmetic: clear MIE, MPIE, MPP then rebuild.
    function automatic bit [31:0] ref_ecall_ms(input bit [31:0] ms);
        return (ms & ~32'h0000_1888) | (((ms >> 3) & 32'h1) << 7) | 32'h0000_1800;
    endfunction

    function automatic bit [31:0] ref_mret_ms(input bit [31:0] ms);
        return (ms & ~32'h0000_1888) | (((ms >> 7) & 32'h1) << 3) | 32'h0000_0080 | 32'h0000_1800;
    endfunction

    // Drive one cycle of stimulus; the model records what an accept implies.
    task automatic step(input bit v, input bit [2:0] op, input bit [2:0] rd,
                        input bit [31:0] old, input bit [31:0] src, input bit [31:0] pc,
                        input bit [31:0] ms, input bit [31:0] tv, input bit [31:0] ep);
        bit        rdy;
        bit [31:0] val;
        in_valid = v; in_op = op; in_csr_rd = rd; in_csr_old = old; in_src = src;
        in_pc = pc; in_mstatus = ms; in_mtvec = tv; in_mepc = ep;
        rdy = (cyc >= next_ok);
        if (v && rdy) begin
            next_ok = cyc + 1;
            case (op)
                3'd1, 3'd2, 3'd3: begin
                    val = (op == 3'd1) ? src : (op == 3'd2) ? (old | src) : (old & ~src);
                    if (!(op != 3'd1 && src == 0)) begin
                        if (rd < 4) exp_q.push_back(mk(cyc + 1, 1, rd, val, 0, 0, 0));
                        else        exp_q.push_back(mk(cyc + 1, 0, 0, 0, 1, 0, 0));
                    end
                end
                3'd4: begin
                    exp_q.push_back(mk(cyc + 1, 1, 3'd2, pc, 0, 0, 0));
                    exp_q.push_back(mk(cyc + 2, 1, 3'd3, 32'hB, 0, 0, 0));
                    exp_q.push_back(mk(cyc + 3, 1, 3'd0, ref_ecall_ms(ms), 0, 1, tv));
                    next_ok = cyc + 3;
                end
                3'd5: exp_q.push_back(mk(cyc + 1, 1, 3'd0, ref_mret_ms(ms), 0, 1, ep));
                default: ;
            endcase
        end
        @(negedge clk);
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (started) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                tests++; fails++;
                $display("FAIL missing_event @cyc %0d: got nothing expected event for cyc %0d", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ev_t e;
                e = exp_q.pop_front();
                chk("CSRWr", {31'b0, CSRWr}, {31'b0, e.wr});
                if (e.wr) begin
                    chk("WBU_csr_rd", {29'b0, WBU_csr_rd}, {29'b0, e.rd});
                    chk("csr_busW", csr_busW, e.data);
                end
                chk("ro_err", {31'b0, ro_err}, {31'b0, e.ro});
                chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, e.redir});
                if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
            end else if (CSRWr !== 1'b0 || ro_err !== 1'b0 || redirect_valid !== 1'b0) begin
                tests++; fails++;
                $display("FAIL unexpected_event @cyc %0d: got wr=%b rd=%0d bus=%h ro=%b redir=%b expected none",
                         cyc, CSRWr, WBU_csr_rd, csr_busW, ro_err, redirect_valid);
            end
        end
    end

    initial begin
        int c0;
        ev_t keep[$];
        repeat (3) @(posedge clk);
        #1;
        chk("rst_CSRWr", {31'b0, CSRWr}, 32'h0);
        chk("rst_rd", {29'b0, WBU_csr_rd}, 32'h0);
        chk("rst_bus", csr_busW, 32'h0);
        chk("rst_redir", {31'b0, redirect_valid}, 32'h0);
        chk("rst_rpc", redirect_pc, 32'h0);
        chk("rst_ro", {31'b0, ro_err}, 32'h0);
        chk("rst_ready", {31'b0, in_ready}, 32'h1);
        rst = 1'b0;
        next_ok = cyc;
        started = 1'b1;

        // Directed scenarios
        step(1, 3'd1, 3'd1, 0, 32'h8000_0100, 0, 0, 0, 0);
        step(1, 3'd2, 3'd0, 32'h1800, 32'h8, 0, 0, 0, 0);
        step(1, 3'd3, 3'd0, 32'h1808, 32'h1000, 0, 0, 0, 0);
        step(1, 3'd4, 3'd0, 0, 0, 32'h8000_0040, 32'h1808, 32'h8000_0200, 0);
        idle(2);
        step(1, 3'd5, 3'd0, 0, 0, 0, 32'h1880, 0, 32'h8000_0044);
        step(1, 3'd1, 3'd4, 0, 32'h1234, 0, 0, 0, 0);
        step(1, 3'd2, 3'd2, 32'h55, 32'h0, 0, 0, 0, 0);
        step(1, 3'd1, 3'd7, 0, 32'h0, 0, 0, 0, 0);
        step(1, 3'd6, 3'd1, 0, 32'h99, 0, 0, 0, 0);
        idle(2);

        // Reset while the ECALL sequence is writing mcause
        c0 = cyc;
        step(1, 3'd4, 3'd0, 0, 0, 32'h8000_0080, 32'h0000_0008, 32'h8000_0300, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        keep = {};
        foreach (exp_q[i]) if (exp_q[i].cyc <= c0 + 2) keep.push_back(exp_q[i]);
        exp_q = keep;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("midrst_CSRWr", {31'b0, CSRWr}, 32'h0);
        chk("midrst_bus", csr_busW, 32'h0);
        chk("midrst_redir", {31'b0, redirect_valid}, 32'h0);
        chk("midrst_ready", {31'b0, in_ready}, 32'h1);
        rst = 1'b0;
        next_ok = cyc;
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit [31:0] src;
            src = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom, src, $urandom, $urandom, $urandom, $urandom);
        end
        idle(5);
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: got %0d pending events expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
